// File: rtl/traffic_phase_timer_if.sv
// Control, configuration and status bundle for traffic_phase_timer.
// The controller side drives the requests; the timer side answers with phase state and strobes.
interface traffic_phase_timer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [WIDTH-1:0] cfg_data;
    logic             running;
    logic [1:0]       phase;
    logic [WIDTH-1:0] remaining;
    logic             tMG;
    logic             tMY;
    logic             tSG;
    logic             tSY;

    modport master (
        output start, stop, hold, cfg_we, cfg_sel, cfg_data,
        input  running, phase, remaining, tMG, tMY, tSG, tSY
    );

    modport slave (
        input  start, stop, hold, cfg_we, cfg_sel, cfg_data,
        output running, phase, remaining, tMG, tMY, tSG, tSY
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// Four-phase traffic timer (MG, MY, SG, SY) with programmable durations,
// freeze, end-of-cycle stop and one-cycle expiry strobes.
module traffic_phase_timer #(
    parameter int WIDTH      = 8,
    parameter int MG_DEFAULT = 15,
    parameter int MY_DEFAULT = 3,
    parameter int SG_DEFAULT = 10,
    parameter int SY_DEFAULT = 3
) (
    input logic                    clk,
    input logic                    sync_reset,
    traffic_phase_timer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, MG, MY, SG, SY} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] DUR_DEFAULT [4] = '{
        WIDTH'(MG_DEFAULT), WIDTH'(MY_DEFAULT), WIDTH'(SG_DEFAULT), WIDTH'(SY_DEFAULT)
    };

    state_t           stateReg;
    logic [WIDTH-1:0] remainingReg;
    logic             stopReg;
    logic             runningReg;
    logic [1:0]       phaseReg;
    logic [3:0]       strobeReg;
    logic [WIDTH-1:0] durReg [4];

    // A zero duration behaves as one cycle, so the load value saturates at 0.
    function automatic logic [WIDTH-1:0] loadValue(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - ONE;
    endfunction

    function automatic state_t nextOf(input state_t s);
        case (s)
            MG:      return MY;
            MY:      return SG;
            SG:      return SY;
            default: return MG;
        endcase
    endfunction

    // Loads read durReg before this edge's write lands, so a same-cycle write uses the old value.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            for (int i = 0; i < 4; i++) durReg[i] <= DUR_DEFAULT[i];
        end else if (bus.cfg_we) begin
            durReg[bus.cfg_sel] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            stateReg     <= IDLE;
            remainingReg <= '0;
            stopReg      <= 1'b0;
            runningReg   <= 1'b0;
            phaseReg     <= 2'd0;
            strobeReg    <= 4'b0000;
        end else begin
            strobeReg <= 4'b0000;
            case (stateReg)
                IDLE: begin
                    if (bus.start) begin
                        stateReg     <= MG;
                        runningReg   <= 1'b1;
                        phaseReg     <= 2'd0;
                        remainingReg <= loadValue(durReg[0]);
                    end
                end
                default: begin
                    if (bus.stop) stopReg <= 1'b1;
                    if (!bus.hold) begin
                        if (remainingReg != '0) begin
                            remainingReg <= remainingReg - ONE;
                        end else begin
                            strobeReg[phaseReg] <= 1'b1;
                            // A stop arriving in the SY expiry cycle itself still counts.
                            if (stateReg == SY && (stopReg || bus.stop)) begin
                                stateReg   <= IDLE;
                                runningReg <= 1'b0;
                                phaseReg   <= 2'd0;
                                stopReg    <= 1'b0;
                            end else begin
                                stateReg     <= nextOf(stateReg);
                                phaseReg     <= phaseReg + 2'd1;
                                remainingReg <= loadValue(durReg[phaseReg + 2'd1]);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.running   = runningReg;
    assign bus.phase     = phaseReg;
    assign bus.remaining = remainingReg;
    assign bus.tMG       = strobeReg[0];
    assign bus.tMY       = strobeReg[1];
    assign bus.tSG       = strobeReg[2];
    assign bus.tSY       = strobeReg[3];
endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed plus randomized checks of traffic_phase_timer against a phase-level reference model.
module tb_traffic_phase_timer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic sync_reset;
    always #5 clk = ~clk;

    traffic_phase_timer_if #(.WIDTH(WIDTH)) bus ();

    traffic_phase_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase index 0..3, cycles left in phase, stop request, last strobe.
    bit mIdle;
    int mPhase;
    int mLeft;
    int mDur [4];
    bit mStop;
    int mStrobe;

    function automatic int effDur(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit st, input bit sp, input bit hd,
                             input bit we, input int sel, input int data);
        int newDur [4];
        if (rst) begin
            mIdle = 1; mPhase = 0; mLeft = 0; mStop = 0; mStrobe = -1;
            mDur = '{15, 3, 10, 3};
            return;
        end
        newDur = mDur;
        if (we) newDur[sel] = data;
        mStrobe = -1;
        if (mIdle) begin
            if (st) begin
                mIdle = 0; mPhase = 0; mLeft = effDur(mDur[0]) - 1;
            end
        end else begin
            mStop = mStop | sp;
            if (!hd) begin
                if (mLeft > 0) mLeft--;
                else begin
                    mStrobe = mPhase;
                    if (mPhase == 3 && mStop) begin
                        mIdle = 1; mPhase = 0; mLeft = 0; mStop = 0;
                    end else begin
                        mPhase = (mPhase + 1) % 4;
                        mLeft = effDur(mDur[mPhase]) - 1;
                    end
                end
            end
        end
        mDur = newDur;
    endtask

    task automatic step(input bit rst, input bit st, input bit sp, input bit hd,
                        input bit we, input int sel, input int data);
        int expStrobe;
        sync_reset   = rst;
        bus.start    = st;
        bus.stop     = sp;
        bus.hold     = hd;
        bus.cfg_we   = we;
        bus.cfg_sel  = 2'(sel);
        bus.cfg_data = WIDTH'(data);
        modelStep(rst, st, sp, hd, we, sel, data);
        @(posedge clk);
        #1;
        expStrobe = (mStrobe < 0) ? 0 : (1 << mStrobe);
        chk("running", int'(bus.running), int'(!mIdle));
        chk("phase", int'(bus.phase), mPhase);
        chk("remaining", int'(bus.remaining), mLeft);
        chk("strobes", int'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), expStrobe);
        $display("t=%0t rst=%0b st=%0b sp=%0b hd=%0b we=%0b sel=%0d d=%0d -> run=%0b ph=%0d rem=%0d str=%b",
                 $time, rst, st, sp, hd, we, sel, data, bus.running, bus.phase, bus.remaining,
                 {bus.tSY, bus.tSG, bus.tMY, bus.tMG});
    endtask

    task automatic idle1();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int firstMG;
        int firstSY;
        int found;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_remaining", int'(bus.remaining), 0);
        idle1();

        // Defaults: tMG in 16th cycle after start, tSY in 32nd
        step(0, 1, 0, 0, 0, 0, 0);
        chk("start_rem", int'(bus.remaining), 14);
        firstMG = -1; firstSY = -1;
        for (int i = 2; i <= 40; i++) begin
            idle1();
            if (bus.tMG && firstMG < 0) firstMG = i;
            if (bus.tSY && firstSY < 0) firstSY = i;
        end
        chk("tMG_cycle", firstMG, 16);
        chk("tSY_cycle", firstSY, 32);

        // MY duration 0 written during MG
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 40; i++) idle1();
        step(0, 0, 0, 0, 1, 1, 3);

        // Hold 5 cycles at SG remaining=4
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus.phase == 2'd2 && bus.remaining == 8'd4) found = 1;
            else idle1();
        end
        chk("reach_SG4", found, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
        chk("hold_frozen", int'(bus.remaining), 4);
        for (int i = 0; i < 10; i++) idle1();

        // Stop pulse during MY
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus.phase == 2'd1) found = 1;
            else idle1();
        end
        chk("reach_MY", found, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            idle1();
            if (bus.tSY) found = 1;
        end
        chk("stop_tSY_seen", found, 1);
        chk("stop_idle", int'(bus.running), 0);
        idle1();
        step(0, 1, 0, 0, 0, 0, 0);
        chk("restart_rem", int'(bus.remaining), 14);

        // Reset at SG remaining=2 after writing MG=7
        step(0, 0, 0, 0, 1, 0, 7);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus.phase == 2'd2 && bus.remaining == 8'd2) found = 1;
            else idle1();
        end
        chk("reach_SG2", found, 1);
        step(1, 1, 0, 0, 1, 0, 9);
        chk("rst_no_strobe", int'({bus.tSY, bus.tSG, bus.tMY, bus.tMG}), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("defaults_restored", int'(bus.remaining), 14);

        // start while running, then start with hold from IDLE
        for (int i = 0; i < 16; i++) idle1();
        step(0, 1, 0, 0, 0, 0, 0);
        chk("start_ignored_phase", int'(bus.phase), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        chk("start_hold_rem", int'(bus.remaining), 14);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
